lmc_rx_cfg_ctrl: RTL
====================

Name: lmc_rx_cfg_ctrl

Overview:
Configuration sequencer for the RX lane-management datapath (LMC_RX: DataHandling + UnStriping). It owns the GEN and LANESNUMBER values driven into that datapath and changes them only through a safe sequence: block, drain, flush, apply, acknowledge. Link-training/rate-change logic requests new settings through a req/ack handshake.

Parameters:
DRAIN_CYCLES, 4, consecutive idle cycles (no valid data) required before flush; legal range ≥1
FLUSH_CYCLES, 2, cycles the datapath reset is held low; legal range ≥1
DEFAULT_GEN, 3'd1, GEN value after reset
DEFAULT_LANES, 5'd1, LANESNUMBER value after reset
TIMEOUT_CYCLES, 64, drain watchdog limit; used only with the optional feature

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active low
cfgReq  input  1  configuration request; level held until cfgAck
cfgGen  input  3  requested GEN; legal values 1..5
cfgLanes  input  5  requested lane count; legal values 1, 2, 4, 8, 16
descramblerDataValid  input  16  per-lane valid into the datapath
LMCValid  input  1  datapath output valid
cfgAck  output  1  one-cycle completion pulse
cfgErr  output  1  qualifies cfgAck; high means the request was rejected
cfgBusy  output  1  high whenever state ≠ IDLE
rxBlock  output  1  gates lane valids into the datapath
lmcReset  output  1  active-low reset to LMC_RX
GEN  output  3  current generation to the datapath
LANESNUMBER  output  5  current lane count to the datapath

Behaviour:
- Reset, sampled synchronously on clk while reset=0:
  - state=IDLE, GEN=DEFAULT_GEN, LANESNUMBER=DEFAULT_LANES.
  - Counters cleared, holding registers cleared.
  - cfgAck=0, cfgErr=0, cfgBusy=0, rxBlock=0.
  - lmcReset = reset AND (state≠FLUSH), so the datapath stays in reset while reset is asserted.
- Outputs are Moore-decoded from registered state:
  - rxBlock is high in BLOCK, FLUSH, APPLY and DONE.
  - cfgAck is high in DONE and REJECT.
  - cfgErr is high only in REJECT.
- IDLE:
  - A request is accepted when cfgReq=1 and cfgAck was 0 in the previous cycle. This forces the requester to drop cfgReq after an ack.
  - On acceptance, cfgGen and cfgLanes are captured into holding registers.
  - Illegal value (gen ∉ 1..5 or lanes not a power of two ≤16) → REJECT.
  - Request equal to the current GEN/LANESNUMBER → DONE; no flush, GEN/LANESNUMBER unchanged.
  - Otherwise → BLOCK.
- BLOCK:
  - The drain counter increments in each cycle where descramblerDataValid==0 and LMCValid==0. Any valid activity resets it to 0.
  - When the counter reaches DRAIN_CYCLES-1 in an idle cycle → FLUSH, so BLOCK lasts at least DRAIN_CYCLES cycles.
- FLUSH: lmcReset=0 for exactly FLUSH_CYCLES cycles, then → APPLY.
- APPLY:
  - One cycle.
  - GEN and LANESNUMBER load the holding registers at the end of this cycle and are visible in DONE.
- DONE: one cycle → IDLE.
- REJECT: one cycle → IDLE; GEN and LANESNUMBER unchanged.
- Latency for a full change (request sampled at cycle 0, defaults D=4, F=2):
  - BLOCK cycles 1–4, FLUSH cycles 5–6, APPLY cycle 7, DONE/cfgAck cycle 8.
  - Reject or no-op: cfgAck at cycle 1.
- cfgReq, cfgGen and cfgLanes are ignored while cfgBusy=1. Changing cfgGen or cfgLanes mid-sequence has no effect.
- Reset asserted mid-sequence: abort immediately, no ack, config returns to defaults.
- Valid activity in the same cycle the drain counter would complete: treated as non-idle; the counter restarts.

Optional Feature:
LMC_CFG_TIMEOUT_EN:
- Defined:
  - A watchdog counts every BLOCK cycle.
  - Reaching TIMEOUT_CYCLES without the drain completing → REJECT (cfgAck=1, cfgErr=1). GEN/LANESNUMBER unchanged; rxBlock released.
- Undefined: BLOCK waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package:
  - State encoding (IDLE, BLOCK, FLUSH, APPLY, DONE, REJECT).
  - Legal GEN range constants and the legal-lane-count check function.
  - Default GEN/lane constants, shared with LMC_RX and the TX lane management control.
- One natural sub-module: lmc_cfg_drain_counter.
  - Holds the idle-run counter and, when enabled, the watchdog.
  - Provides drainDone and timeout flags to the FSM.

Test Plan:
1. Reset, then request gen=3 lanes=4 with the datapath idle → cfgAck at cycle 8, cfgErr=0; lmcReset low in cycles 5–6; GEN=3 and LANESNUMBER=4 from cycle 8.
2. Request gen=2 lanes=8 while descramblerDataValid pulses at BLOCK cycles 2 and 3 → drain restarts after each pulse; FLUSH begins only after 4 consecutive idle cycles.
3. Request lanes=6, then separately gen=7 → cfgAck and cfgErr both high at cycle 1 in each case; config unchanged; lmcReset never low.
4. Request equal to the current config (gen=1 lanes=1 after reset) → cfgAck at cycle 1, cfgErr=0, no flush. Holding cfgReq high through the ack produces no second acceptance.
5. Assert reset at FLUSH cycle 1 → no ack, state IDLE, GEN=1, LANESNUMBER=1, lmcReset=0 while reset is low.
6. With LMC_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=64, hold LMCValid=1 → cfgAck with cfgErr=1 after 64 BLOCK cycles; rxBlock drops; config unchanged.

Source files
------------

// File: rtl/lmc_rx_cfg_ctrl_pkg.sv
// Shared definitions for the LMC_RX configuration sequencer.
//   - cfg_state_t : sequencer state encoding
//   - GEN_MIN/GEN_MAX, gen_legal(), lanes_legal() : request legality checks
//   - LMC_DEFAULT_GEN / LMC_DEFAULT_LANES : post-reset link configuration,
//     also used by LMC_RX and the TX lane management control
package lmc_rx_cfg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLOCK  = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_APPLY  = 3'd3,
    ST_DONE   = 3'd4,
    ST_REJECT = 3'd5
  } cfg_state_t;

  localparam logic [2:0] GEN_MIN           = 3'd1;
  localparam logic [2:0] GEN_MAX           = 3'd5;
  localparam logic [2:0] LMC_DEFAULT_GEN   = 3'd1;
  localparam logic [4:0] LMC_DEFAULT_LANES = 5'd1;

  function automatic logic gen_legal(input logic [2:0] g);
    return (g >= GEN_MIN) && (g <= GEN_MAX);
  endfunction

  // A 5-bit power of two is automatically <= 16.
  function automatic logic lanes_legal(input logic [4:0] l);
    return (l != 5'd0) && ((l & (l - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/lmc_cfg_drain_counter.sv
// Drain detector for the configuration sequencer.
// Counts consecutive idle cycles while the sequencer is blocking the
// datapath and, when LMC_CFG_TIMEOUT_EN is defined, runs a watchdog over
// the whole blocking period.
// Ports:
//   clk, reset (sync, active low)
//   active    : sequencer is in BLOCK
//   idle      : no lane valid and no datapath output valid this cycle
//   drainDone : this cycle completes DRAIN_CYCLES consecutive idle cycles
//   timeout   : this cycle is the TIMEOUT_CYCLES-th blocking cycle and the
//               drain did not complete (always 0 without LMC_CFG_TIMEOUT_EN)
module lmc_cfg_drain_counter
  import lmc_rx_cfg_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic idle,
  output logic drainDone,
  output logic timeout
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [DW-1:0] idleRun;

  // Any activity restarts the run, including activity in the cycle that
  // would otherwise have completed it.
  always_ff @(posedge clk) begin
    if (!reset || !active || !idle) begin
      idleRun <= '0;
    end else if (idleRun != DRAIN_LAST) begin
      idleRun <= idleRun + 1'b1;
    end
  end

  assign drainDone = active && idle && (idleRun == DRAIN_LAST);

`ifdef LMC_CFG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wdCnt;

  always_ff @(posedge clk) begin
    if (!reset || !active) begin
      wdCnt <= '0;
    end else if (wdCnt != WD_LAST) begin
      wdCnt <= wdCnt + 1'b1;
    end
  end

  // A drain that completes on the last allowed cycle still wins.
  assign timeout = active && (wdCnt == WD_LAST) && !drainDone;
`else
  // Watchdog compiled out: constant false, TIMEOUT_CYCLES kept referenced
  // so both builds share one parameter interface.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: rtl/lmc_rx_cfg_ctrl.sv
// Configuration sequencer for the RX lane-management datapath (LMC_RX).
// Owns GEN / LANESNUMBER and changes them only via
// block -> drain -> flush -> apply -> acknowledge.
// Optional build macro: LMC_CFG_TIMEOUT_EN (drain watchdog -> reject).
// Ports:
//   clk, reset (sync, active low)
//   cfgReq/cfgGen/cfgLanes : level request, held until cfgAck
//   descramblerDataValid   : per-lane valid into the datapath
//   LMCValid               : datapath output valid
//   cfgAck/cfgErr          : one-cycle completion, cfgErr marks a rejection
//   cfgBusy                : sequence in progress
//   rxBlock                : gates lane valids into the datapath
//   lmcReset               : active-low datapath reset
//   GEN/LANESNUMBER        : current configuration to the datapath
module lmc_rx_cfg_ctrl
  import lmc_rx_cfg_ctrl_pkg::*;
#(
  parameter int         DRAIN_CYCLES   = 4,
  parameter int         FLUSH_CYCLES   = 2,
  parameter logic [2:0] DEFAULT_GEN    = LMC_DEFAULT_GEN,
  parameter logic [4:0] DEFAULT_LANES  = LMC_DEFAULT_LANES,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfgReq,
  input  logic [2:0]  cfgGen,
  input  logic [4:0]  cfgLanes,
  input  logic [15:0] descramblerDataValid,
  input  logic        LMCValid,
  output logic        cfgAck,
  output logic        cfgErr,
  output logic        cfgBusy,
  output logic        rxBlock,
  output logic        lmcReset,
  output logic [2:0]  GEN,
  output logic [4:0]  LANESNUMBER
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  cfg_state_t    state;
  cfg_state_t    nxt;
  logic [2:0]    holdGen;
  logic [4:0]    holdLanes;
  logic [FW-1:0] flushCnt;
  logic          ackPrev;
  logic          accept;
  logic          reqLegal;
  logic          reqSame;
  logic          dpIdle;
  logic          drainDone;
  logic          timeout;

  assign dpIdle   = (descramblerDataValid == 16'd0) && !LMCValid;
  // Requiring cfgAck low in the previous cycle forces the requester to
  // drop cfgReq after an ack before a new request is taken.
  assign accept   = cfgReq && !ackPrev;
  assign reqLegal = gen_legal(cfgGen) && lanes_legal(cfgLanes);
  assign reqSame  = (cfgGen == GEN) && (cfgLanes == LANESNUMBER);

  lmc_cfg_drain_counter #(
    .DRAIN_CYCLES   (DRAIN_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_drain (
    .clk       (clk),
    .reset     (reset),
    .active    (state == ST_BLOCK),
    .idle      (dpIdle),
    .drainDone (drainDone),
    .timeout   (timeout)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!reqLegal)    nxt = ST_REJECT;
          else if (reqSame) nxt = ST_DONE;
          else              nxt = ST_BLOCK;
        end
      end
      ST_BLOCK: begin
        if (drainDone)    nxt = ST_FLUSH;
        else if (timeout) nxt = ST_REJECT;
      end
      ST_FLUSH: begin
        if (flushCnt == FLUSH_LAST) nxt = ST_APPLY;
      end
      ST_APPLY:  nxt = ST_DONE;
      ST_DONE:   nxt = ST_IDLE;
      ST_REJECT: nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // registered state they decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      GEN         <= DEFAULT_GEN;
      LANESNUMBER <= DEFAULT_LANES;
      holdGen     <= '0;
      holdLanes   <= '0;
      flushCnt    <= '0;
      ackPrev     <= 1'b0;
      cfgAck      <= 1'b0;
      cfgErr      <= 1'b0;
      cfgBusy     <= 1'b0;
      rxBlock     <= 1'b0;
    end else begin
      state   <= nxt;
      ackPrev <= cfgAck;
      if ((state == ST_IDLE) && accept) begin
        holdGen   <= cfgGen;
        holdLanes <= cfgLanes;
      end
      if (state == ST_FLUSH) flushCnt <= flushCnt + 1'b1;
      else                   flushCnt <= '0;
      if (state == ST_APPLY) begin
        GEN         <= holdGen;
        LANESNUMBER <= holdLanes;
      end
      cfgAck  <= (nxt == ST_DONE) || (nxt == ST_REJECT);
      cfgErr  <= (nxt == ST_REJECT);
      cfgBusy <= (nxt != ST_IDLE);
      rxBlock <= (nxt == ST_BLOCK) || (nxt == ST_FLUSH) ||
                 (nxt == ST_APPLY) || (nxt == ST_DONE);
    end
  end

  // Combinational with the reset input so the datapath is held in reset
  // for as long as this block is.
  assign lmcReset = reset && (state != ST_FLUSH);

endmodule
